mem_ctrl: RTL and testbench

CPU-side memory access controller: the initiator for the shared byte-wide unified instruction/data RAM. It arbitrates between instruction fetch (pc_reg/if stage) and load/store (mem stage), serialises each access into 1/2/4 single-byte RAM cycles, and reassembles little-endian read data. It raises `stall_req` to ctrl until the outstanding pipeline request completes.

---
 rtl/mem_ctrl_if.sv | 36 +++
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Pipeline-side request/response and byte-wide RAM signals of the
// memory access controller.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] inst;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_valid_bit;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_req;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_valid_bit, mem_addr, mem_wdata,
        output ram_din,
        input  inst, if_done, mem_rdata, mem_done, stall_req,
        input  ram_a, ram_dout, ram_wr
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_valid_bit, mem_addr, mem_wdata,
        input  ram_din,
        output inst, if_done, mem_rdata, mem_done, stall_req,
        output ram_a, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store onto a byte-wide RAM, serialising
// each access into 1/2/4 byte cycles with little-endian assembly.
module mem_ctrl (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  nm1_q, nm1_d;
    logic        pend_q, pend_d;
    logic        src_q, src_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  cnt_inc;
    logic [1:0]  mem_nm1;
    logic [31:0] asm_nxt;

    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        case (bus.mem_valid_bit)
            2'b00:   mem_nm1 = 2'd0;
            2'b01:   mem_nm1 = 2'd1;
            default: mem_nm1 = 2'd3;
        endcase
    end

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{cnt_q, 3'b000} +: 8] = bus.ram_din;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nm1_d      = nm1_q;
        pend_d     = pend_q;
        src_d      = src_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;
        inst_d     = inst_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = 2'd0;
                pend_d = 1'b0;
                asm_d  = 32'd0;
                if (bus.mem_req) begin
                    src_d   = 1'b1;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    nm1_d   = mem_nm1;
                    ram_a_d = bus.mem_addr;
                    if (bus.mem_we) begin
                        ram_dout_d = bus.mem_wdata[7:0];
                        ram_wr_d   = 1'b1;
                        state_d    = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end else if (bus.if_req) begin
                    src_d   = 1'b0;
                    addr_d  = bus.if_addr;
                    nm1_d   = 2'd3;
                    ram_a_d = bus.if_addr;
                    state_d = READ;
                end
            end
            READ: begin
                // pend_q marks that ram_din now carries lane cnt_q
                if (!pend_q) begin
                    pend_d = 1'b1;
                    if (nm1_q != 2'd0) ram_a_d = addr_q + 32'd1;
                end else begin
                    asm_d = asm_nxt;
                    if (cnt_q == nm1_q) begin
                        state_d = DONE;
                        if (src_q) rdata_d = asm_nxt;
                        else       inst_d  = asm_nxt;
                    end else begin
                        cnt_d = cnt_inc;
                        if ({1'b0, cnt_q} + 3'd2 <= {1'b0, nm1_q})
                            ram_a_d = addr_q + {30'd0, cnt_q} + 32'd2;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == nm1_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d      = cnt_inc;
                    ram_a_d    = addr_q + {30'd0, cnt_inc};
                    ram_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            nm1_q      <= 2'd0;
            pend_q     <= 1'b0;
            src_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            asm_q      <= 32'd0;
            ram_a_q    <= 32'd0;
            ram_dout_q <= 8'd0;
            ram_wr_q   <= 1'b0;
            inst_q     <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nm1_q      <= nm1_d;
            pend_q     <= pend_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            inst_q     <= inst_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.inst      = inst_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.if_done   = (state_q == DONE) && !src_q;
    assign bus.mem_done  = (state_q == DONE) && src_q;
    assign bus.stall_req = (bus.mem_req & ~bus.mem_done)
                         | (bus.if_req & ~bus.if_done);
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, reference byte memory and
// randomized accesses mixed with the directed scenarios.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit [7:0] ram     [0:65535];
    bit [7:0] ref_mem [0:65535];
    logic [31:0] wa_q [$];
    logic [7:0]  wd_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) begin
        if (bus.ram_wr) begin
            ram[bus.ram_a[15:0]] <= bus.ram_dout;
            wa_q.push_back(bus.ram_a);
            wd_q.push_back(bus.ram_dout);
        end
        bus.ram_din <= ram[bus.ram_a[15:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] vb);
        return (vb == 2'b00) ? 1 : (vb == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++)
            w |= {24'd0, ref_mem[16'(a + 32'(k))]} << (8 * k);
        return w;
    endfunction

    task automatic access(input bit fetch, input bit we,
                          input logic [1:0] vb, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int n, lat, bad, want_lat;
        logic [31:0] exp, got, old_rdata;
        logic st_done;
        n   = fetch ? 4 : size_of(vb);
        exp = ref_word(addr, n);
        old_rdata = bus.mem_rdata;
        wa_q.delete();
        wd_q.delete();
        if (fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req       = 1'b1;
            bus.mem_we        = we;
            bus.mem_valid_bit = vb;
            bus.mem_addr      = addr;
            bus.mem_wdata     = wdata;
        end
        lat = 0;
        bad = 0;
        st_done = 1'b1;
        while (1) begin
            tick();
            lat++;
            if (lat <= n && (bus.ram_a !== addr + 32'(lat - 1) ||
                bus.ram_wr !== (!fetch && we)))
                bad++;
            if (bus.if_done || bus.mem_done) begin
                st_done = bus.stall_req;
                break;
            end
            if (!bus.stall_req) bad++;
            if (lat > 20) break;
        end
        want_lat = (!fetch && we) ? n + 1 : n + 2;
        chk({tag, " latency"}, 32'(lat), 32'(want_lat));
        chk({tag, " ram_a/stall seq"}, 32'(bad), 32'd0);
        chk({tag, " done source"}, {31'd0, bus.if_done}, {31'd0, fetch});
        chk({tag, " stall in done"}, {31'd0, st_done}, 32'd0);
        got = fetch ? bus.inst : bus.mem_rdata;
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        if (!fetch && we) begin
            chk({tag, " rdata kept"}, bus.mem_rdata, old_rdata);
            chk({tag, " write count"}, 32'(wa_q.size()), 32'(n));
            for (int k = 0; k < n; k++) begin
                ref_mem[16'(addr + 32'(k))] = wdata[8*k +: 8];
                if (k < wa_q.size()) begin
                    chk({tag, " wr addr"}, wa_q[k], addr + 32'(k));
                    chk({tag, " wr byte"}, {24'd0, wd_q[k]},
                        {24'd0, wdata[8*k +: 8]});
                end
            end
        end else begin
            chk({tag, " data"}, got, exp);
            chk({tag, " no writes"}, 32'(wa_q.size()), 32'd0);
        end
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ram_a"}, bus.ram_a, 32'd0);
        chk({tag, " ram_dout"}, {24'd0, bus.ram_dout}, 32'd0);
        chk({tag, " ram_wr"}, {31'd0, bus.ram_wr}, 32'd0);
        chk({tag, " inst"}, bus.inst, 32'd0);
        chk({tag, " mem_rdata"}, bus.mem_rdata, 32'd0);
        chk({tag, " if_done"}, {31'd0, bus.if_done}, 32'd0);
        chk({tag, " mem_done"}, {31'd0, bus.mem_done}, 32'd0);
    endtask

    initial begin
        int t_md, t_id, dones;
        logic [31:0] rd, ins, a6;
        logic st4;
        bus.if_req = 0; bus.if_addr = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_valid_bit = 0;
        bus.mem_addr = 0; bus.mem_wdata = 0;
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_outs("reset");
        chk("reset stall", {31'd0, bus.stall_req}, 32'd0);
        rst = 1'b0;
        tick();

        access(0, 1, 2'b10, 32'h100, 32'h00100513, "st fetch word");
        access(1, 0, 2'b10, 32'h100, 32'h0, "word fetch");
        chk("fetch inst", bus.inst, 32'h00100513);
        access(0, 1, 2'b00, 32'h30004, 32'h12345678, "byte store");
        chk("byte ram", {24'd0, ram[16'h0004]}, 32'h78);

        access(0, 1, 2'b01, 32'h200, 32'h0000CDAB, "st half");
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.mem_req = 1; bus.mem_we = 0;
        bus.mem_valid_bit = 2'b01; bus.mem_addr = 32'h200;
        t_md = -1; t_id = -1; rd = 0; ins = 0; st4 = 0; a6 = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 6) a6 = bus.ram_a;
            if (bus.mem_done) begin
                t_md = c; rd = bus.mem_rdata; st4 = bus.stall_req;
                bus.mem_req = 0;
            end
            if (bus.if_done) begin
                t_id = c; ins = bus.inst; bus.if_req = 0;
                break;
            end
        end
        bus.if_req = 0; bus.mem_req = 0;
        tick();
        chk("simul mem_done t", 32'(t_md), 32'd4);
        chk("simul rdata", rd, 32'h0000CDAB);
        chk("simul stall at done", {31'd0, st4}, 32'd1);
        chk("simul fetch ram_a", a6, 32'h100);
        chk("simul if_done t", 32'(t_id), 32'd11);
        chk("simul inst", ins, 32'h00100513);

        access(0, 1, 2'b10, 32'h1000, 32'hDEADBEEF, "st word");
        chk("ram 1000..1003", {ram[16'h1003], ram[16'h1002],
            ram[16'h1001], ram[16'h1000]}, 32'hDEADBEEF);
        access(0, 0, 2'b10, 32'h1000, 32'h0, "ld word");
        chk("ld deadbeef", bus.mem_rdata, 32'hDEADBEEF);

        bus.if_req = 1; bus.if_addr = 32'h1000;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_reset_outs("rst mid");
        rst = 1'b0;
        bus.if_req = 0;
        dones = 0;
        repeat (10) begin
            tick();
            if (bus.if_done || bus.ram_wr) dones++;
        end
        chk("rst no done", 32'(dones), 32'd0);
        access(1, 0, 2'b10, 32'h1000, 32'h0, "fetch after rst");
        chk("fetch after rst inst", bus.inst, 32'hDEADBEEF);

        access(0, 1, 2'b10, 32'hFFFFFFFE, 32'h44332211, "wrap st");
        access(0, 0, 2'b10, 32'hFFFFFFFE, 32'h0, "wrap ld");
        chk("wrap value", bus.mem_rdata, 32'h44332211);
        access(0, 0, 2'b11, 32'h1000, 32'h0, "reserved size");

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [1:0] vb;
            logic [31:0] a, wd;
            kind = $urandom_range(0, 2);
            vb   = 2'($urandom_range(0, 3));
            a    = 32'h2000 + 32'($urandom_range(0, 63));
            wd   = $urandom;
            if (kind == 0)      access(1, 0, vb, a, wd, "rnd fetch");
            else if (kind == 1) access(0, 0, vb, a, wd, "rnd load");
            else                access(0, 1, vb, a, wd, "rnd store");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
